// File: rtl/output_store_if.sv
// Memory write port of output_store: request (wr_en/addr/data) and the
// memory's ready back-pressure.
interface output_store_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  mem_ready;

    modport master (output wr_en, wr_addr, wr_data, input mem_ready);
    modport slave  (input wr_en, wr_addr, wr_data, output mem_ready);
endinterface

// File: rtl/output_store.sv
// Output store: picks one accumulator lane, shifts/saturates it to a word,
// buffers it in a small FIFO and streams it to memory. Define RELU_EN to clamp negatives.
module output_store_lane #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 8
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] word
);
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0]  top;
    logic [DATA_WIDTH-1:0]          sat;

    assign shifted = $signed(acc) >>> SHIFT;
    assign top     = shifted[ACC_WIDTH-1:DATA_WIDTH-1];

    // In range only when every bit above the word's sign bit matches it.
    always_comb begin
        if ((&top) || (~|top))
            sat = shifted[DATA_WIDTH-1:0];
        else if (shifted[ACC_WIDTH-1])
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

`ifdef RELU_EN
    assign word = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    assign word = sat;
`endif
endmodule

module output_store #(
    parameter int DATA_WIDTH  = 16,
    parameter int TILING_SIZE = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int SHIFT       = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [ADDR_WIDTH-1:0]            out_len,
    input  logic                             valid_data,
    input  logic [3:0]                       sel_data,
    input  logic [TILING_SIZE*ACC_WIDTH-1:0] acc_data,
    output_store_if.master                   mem,
    output logic                             fifo_full,
    output logic                             overflow_err,
    output logic                             done
);
    localparam int STAGES = 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FINISH} state_t;

    logic [TILING_SIZE-1:0][ACC_WIDTH-1:0]  acc_lane;
    logic [TILING_SIZE-1:0][DATA_WIDTH-1:0] lane_word;
    logic [DATA_WIDTH-1:0]                  cap_word;
    logic                                   cap_hit;
    logic                                   cap_vld;

    logic [STAGES:1]       vld_q;
    logic [STAGES:0]       vld_pipe;
    logic [DATA_WIDTH-1:0] stage_data;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wt_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  push, push_ok, pop, drop;
    logic [DATA_WIDTH-1:0] head_next;

    state_t                state;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, last_addr;
    logic [DATA_WIDTH-1:0] wr_data_q;

    assign acc_lane = acc_data;

    for (genvar g = 0; g < TILING_SIZE; g++) begin : g_lane
        output_store_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .SHIFT     (SHIFT)
        ) u_lane (
            .acc (acc_lane[g]),
            .word(lane_word[g])
        );
    end

    // sel_data is 1-based; 0 and anything past the last lane match nothing.
    always_comb begin
        cap_word = '0;
        cap_hit  = 1'b0;
        for (int i = 0; i < TILING_SIZE; i++) begin
            if (sel_data == 4'(i + 1)) begin
                cap_word = lane_word[i];
                cap_hit  = 1'b1;
            end
        end
    end

    assign cap_vld  = valid_data & cap_hit;
    assign vld_pipe = {vld_q, cap_vld};

    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = (state == S_WRITE) & wr_en_q & mem.mem_ready;
    assign push      = vld_pipe[STAGES];
    assign push_ok   = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;
    assign last_addr = out_len - ADDR_WIDTH'(1);
    // With a single entry left, the next head is the word being pushed right now.
    assign head_next = (fifo_cnt == CNT_W'(1)) ? stage_data : fifo_mem[rd_ptr + PTR_W'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            stage_data <= '0;
            rd_ptr     <= '0;
            wt_ptr     <= '0;
            fifo_cnt   <= '0;
        end else if (clear) begin
            vld_q      <= '0;
            stage_data <= '0;
            rd_ptr     <= '0;
            wt_ptr     <= '0;
            fifo_cnt   <= '0;
        end else begin
            vld_q <= vld_pipe[STAGES-1:0];
            if (cap_vld) stage_data <= cap_word;
            if (push_ok) wt_ptr <= wt_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) fifo_mem[wt_ptr] <= stage_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (drop) overflow_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (fifo_cnt != '0) begin
                        state     <= S_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= fifo_mem[rd_ptr];
                    end
                end
                S_WRITE: begin
                    if (pop) begin
                        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                        if (wr_addr_q == last_addr) begin
                            state   <= S_FINISH;
                            wr_en_q <= 1'b0;
                            done    <= 1'b1;
                        end else if (fifo_cnt != CNT_W'(1) || push_ok) begin
                            wr_data_q <= head_next;
                        end else begin
                            state   <= S_IDLE;
                            wr_en_q <= 1'b0;
                        end
                    end
                end
                S_FINISH: begin
                    wr_addr_q <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem.wr_en   = wr_en_q;
    assign mem.wr_addr = wr_addr_q;
    assign mem.wr_data = wr_data_q;
endmodule

// File: tb/tb_output_store.sv
// Bench for output_store: directed scenarios plus randomized bursts checked
// against an arithmetic reference of the conversion and address/done sequencing.
module tb_output_store;
    localparam int DW = 16, TS = 8, ACC = 32, AW = 16, SH = 8, FD = 4;

    logic              clk = 1'b0, rst_n = 1'b1, clear = 1'b0, valid_data = 1'b0;
    logic [3:0]        sel_data = '0;
    logic [TS*ACC-1:0] acc_data = '0;
    logic [AW-1:0]     out_len = AW'(100);
    logic              done, fifo_full, overflow_err;

    output_store_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    output_store #(
        .DATA_WIDTH(DW), .TILING_SIZE(TS), .ACC_WIDTH(ACC),
        .ADDR_WIDTH(AW), .SHIFT(SH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .out_len(out_len),
        .valid_data(valid_data), .sel_data(sel_data), .acc_data(acc_data),
        .mem(mem_if), .fifo_full(fifo_full), .overflow_err(overflow_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] d; logic [AW-1:0] a; } wr_t;
    wr_t got_q[$];
    int  errors = 0, checks = 0, done_cnt = 0;
    time done_t = 0, last_acc_t = 0;

    // An accept is wr_en&mem_ready seen mid-cycle; it completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (mem_if.wr_en && mem_if.mem_ready) begin
                got_q.push_back('{mem_if.wr_data, mem_if.wr_addr});
                last_acc_t = $time;
            end
            if (done) begin
                done_cnt++;
                done_t = $time;
            end
        end
    end

    function automatic logic [DW-1:0] ref_conv(input logic [ACC-1:0] a);
        longint v, q, div, lim;
        v   = longint'($signed(a));
        div = longint'(1) << SH;
        q   = v / div;
        if (v < 0 && (v % div) != 0) q = q - 1;
        lim = longint'(1) << (DW - 1);
        if (q > lim - 1) q = lim - 1;
        else if (q < -lim) q = -lim;
`ifdef RELU_EN
        if (q < 0) q = 0;
`endif
        return q[DW-1:0];
    endfunction

    function automatic logic [ACC-1:0] rnd_acc();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = {{8{r[23]}}, r[23:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [ACC-1:0] v);
        acc_data[i*ACC +: ACC] = v;
    endtask

    function automatic logic [ACC-1:0] get_lane(input int i);
        return acc_data[i*ACC +: ACC];
    endfunction

    task automatic do_clear();
        mem_if.mem_ready = 1'b0;
        valid_data = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", mem_if.wr_en); end
        checks++; if (mem_if.wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", mem_if.wr_addr); end
        checks++; if (mem_if.wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", mem_if.wr_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        do_clear();
        out_len = AW'(100);
        set_lane(2, 32'h0000_1200);
        valid_data = 1'b1; sel_data = 4'd3; mem_if.mem_ready = 1'b1;
        tick();
        valid_data = 1'b0;
        checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL lat_early1: wr_en %b want 0", mem_if.wr_en); end
        tick();
        checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL lat_early2: wr_en %b want 0", mem_if.wr_en); end
        tick();
        checks++; if (mem_if.wr_en !== 1'b1) begin errors++; $display("FAIL lat_wr_en: got %b want 1", mem_if.wr_en); end
        checks++; if (mem_if.wr_data !== 16'h0012) begin errors++; $display("FAIL lat_wr_data: got %h want 0012", mem_if.wr_data); end
        checks++; if (mem_if.wr_addr !== AW'(0)) begin errors++; $display("FAIL lat_wr_addr: got %h want 0", mem_if.wr_addr); end
        tick();
        checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL lat_after: wr_en %b want 0", mem_if.wr_en); end
        checks++; if (mem_if.wr_addr !== AW'(1)) begin errors++; $display("FAIL lat_addr_inc: got %h want 1", mem_if.wr_addr); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL lat_count: got %0d want 1", got_q.size()); end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_saturation();
        logic [ACC-1:0] vin [4];
        logic [DW-1:0]  vexp [4];
        vin[0] = 32'h7FFF_0000; vexp[0] = 16'h7FFF;
        vin[1] = 32'hFFFF_FF00;
        vin[2] = 32'h8000_0000;
        vin[3] = 32'h0000_7F80; vexp[3] = 16'h007F;
`ifdef RELU_EN
        vexp[1] = 16'h0000; vexp[2] = 16'h0000;
`else
        vexp[1] = 16'hFFFF; vexp[2] = 16'h8000;
`endif
        do_clear();
        out_len = AW'(100);
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_lane(0, vin[i]);
            valid_data = 1'b1; sel_data = 4'd1;
            tick();
        end
        valid_data = 1'b0;
        for (int k = 0; k < 20 && got_q.size() < 4; k++) tick();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL sat_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i].d !== vexp[i] || got_q[i].a !== AW'(i)) begin
                errors++; $display("FAIL sat_word%0d: got %h@%h want %h@%h", i, got_q[i].d, got_q[i].a, vexp[i], AW'(i));
            end
        end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] e [4];
        do_clear();
        out_len = AW'(100);
        for (int i = 0; i < TS; i++) set_lane(i, rnd_acc());
        for (int i = 0; i < 4; i++) e[i] = ref_conv(get_lane(i));
        for (int s = 0; s <= 8; s++) begin
            valid_data = 1'b1; sel_data = 4'(s);
            tick();
        end
        valid_data = 1'b0;
        tick(); tick();
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", overflow_err); end
        checks++; if (mem_if.wr_en !== 1'b1 || mem_if.wr_data !== e[0]) begin
            errors++; $display("FAIL ovf_head: wr_en %b data %h want 1 %h", mem_if.wr_en, mem_if.wr_data, e[0]);
        end
        mem_if.mem_ready = 1'b1;
        for (int k = 0; k < 20 && got_q.size() < 4; k++) tick();
        tick(); tick();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL ovf_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i].d !== e[i] || got_q[i].a !== AW'(i)) begin
                errors++; $display("FAIL ovf_word%0d: got %h@%h want %h@%h", i, got_q[i].d, got_q[i].a, e[i], AW'(i));
            end
        end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_drained: full %b want 0", fifo_full); end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_done();
        logic [DW-1:0] e [3];
        do_clear();
        out_len = AW'(3);
        mem_if.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int l;
            l = $urandom_range(0, TS - 1);
            set_lane(l, rnd_acc());
            e[i] = ref_conv(get_lane(l));
            valid_data = 1'b1; sel_data = 4'(l + 1);
            tick();
        end
        valid_data = 1'b0;
        for (int k = 0; k < 30 && got_q.size() < 3; k++) tick();
        tick(); tick(); tick();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL done_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i].d !== e[i] || got_q[i].a !== AW'(i)) begin
                errors++; $display("FAIL done_word%0d: got %h@%h want %h@%h", i, got_q[i].d, got_q[i].a, e[i], AW'(i));
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        checks++; if (done_t - last_acc_t != 10) begin errors++; $display("FAIL done_timing: got %0t want 10", done_t - last_acc_t); end
        checks++; if (mem_if.wr_addr !== AW'(0)) begin errors++; $display("FAIL done_wrap: addr %h want 0", mem_if.wr_addr); end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [DW-1:0] e0, e1;
        do_clear();
        out_len = AW'(100);
        set_lane(4, rnd_acc()); e0 = ref_conv(get_lane(4));
        valid_data = 1'b1; sel_data = 4'd5;
        tick();
        set_lane(6, rnd_acc()); e1 = ref_conv(get_lane(6));
        sel_data = 4'd7;
        tick();
        valid_data = 1'b0;
        for (int k = 0; k < 10 && !mem_if.wr_en; k++) tick();
        tick();
        checks++; if (mem_if.wr_en !== 1'b1 || mem_if.wr_data !== e0 || mem_if.wr_addr !== AW'(0)) begin
            errors++; $display("FAIL stall_first: %b %h@%h want 1 %h@0", mem_if.wr_en, mem_if.wr_data, mem_if.wr_addr, e0);
        end
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        checks++; if (mem_if.wr_en !== 1'b1 || mem_if.wr_data !== e1 || mem_if.wr_addr !== AW'(1)) begin
            errors++; $display("FAIL stall_second: %b %h@%h want 1 %h@1", mem_if.wr_en, mem_if.wr_data, mem_if.wr_addr, e1);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (mem_if.wr_en !== 1'b1 || mem_if.wr_data !== e1 || mem_if.wr_addr !== AW'(1)) begin
                errors++; $display("FAIL stall_hold%0d: %b %h@%h want 1 %h@1", k, mem_if.wr_en, mem_if.wr_data, mem_if.wr_addr, e1);
            end
        end
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        checks++; if (mem_if.wr_en !== 1'b0 || mem_if.wr_addr !== AW'(2)) begin
            errors++; $display("FAIL stall_end: wr_en %b addr %h want 0 @2", mem_if.wr_en, mem_if.wr_addr);
        end
        checks++; if (got_q.size() != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", got_q.size()); end
        else begin
            checks++; if (got_q[0].d !== e0 || got_q[0].a !== AW'(0) || got_q[1].d !== e1 || got_q[1].a !== AW'(1)) begin
                errors++; $display("FAIL stall_seq: got %h@%h %h@%h want %h@0 %h@1", got_q[0].d, got_q[0].a, got_q[1].d, got_q[1].a, e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        out_len = AW'(100);
        for (int i = 0; i < 3; i++) begin
            set_lane(i, rnd_acc());
            valid_data = 1'b1; sel_data = 4'(i + 1);
            tick();
        end
        valid_data = 1'b0;
        tick(); tick(); tick();
        checks++; if (mem_if.wr_en !== 1'b1) begin errors++; $display("FAIL rmid_pending: wr_en %b want 1", mem_if.wr_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b want 0", mem_if.wr_en); end
        checks++; if (overflow_err !== 1'b0 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL rmid_flags: ovf %b full %b want 0 0", overflow_err, fifo_full);
        end
        checks++; if (mem_if.wr_addr !== '0 || mem_if.wr_data !== '0) begin
            errors++; $display("FAIL rmid_bus: %h@%h want 0@0", mem_if.wr_data, mem_if.wr_addr);
        end
        tick();
        rst_n = 1'b1;
        mem_if.mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (mem_if.wr_en !== 1'b0) begin errors++; $display("FAIL rmid_release%0d: wr_en %b want 0", k, mem_if.wr_en); end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_writes: got %0d want 0", got_q.size()); end
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q[$];
        int            len;
        do_clear();
        len = $urandom_range(2, 6);
        out_len = AW'(len);
        for (int b = 0; b < 8; b++) begin
            int nv;
            nv = 0;
            for (int c = 0; c < 10 && nv < 4; c++) begin
                logic       v;
                logic [3:0] s;
                for (int i = 0; i < TS; i++) set_lane(i, rnd_acc());
                v = 1'($urandom_range(0, 1));
                s = 4'($urandom_range(0, 15));
                mem_if.mem_ready = 1'($urandom_range(0, 1));
                valid_data = v; sel_data = s;
                if (v && s >= 1 && s <= TS) begin
                    exp_q.push_back(ref_conv(get_lane(int'(s) - 1)));
                    nv++;
                end
                tick();
            end
            valid_data = 1'b0;
            for (int k = 0; k < 80 && got_q.size() < exp_q.size(); k++) begin
                mem_if.mem_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            mem_if.mem_ready = 1'b0;
            tick(); tick();
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].d !== exp_q[i] || got_q[i].a !== AW'(i % len)) begin
                errors++; $display("FAIL rnd_word%0d: got %h@%h want %h@%h", i, got_q[i].d, got_q[i].a, exp_q[i], AW'(i % len));
            end
        end
        checks++; if (done_cnt != exp_q.size() / len) begin errors++; $display("FAIL rnd_done: got %0d want %0d", done_cnt, exp_q.size() / len); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rnd_overflow: got %b want 0", overflow_err); end
    endtask

    initial begin
        mem_if.mem_ready = 1'b0;
        test_reset();
        test_latency();
        test_saturation();
        test_overflow();
        test_done();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/output_store.md
OUTPUT_STORE -- requirements
Module: output_store

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 16, output word width; TILING_SIZE, 8, lanes per tile; ACC_WIDTH, 32, accumulator lane width; ADDR_WIDTH, 16, memory address width; SHIFT, 8, fixed-point right shift; FIFO_DEPTH, 4, buffer entries (power of 2).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clear, in, 1, synchronous clear of address, count, FIFO, error.
- out_len, in, ADDR_WIDTH, number of words per layer.
- valid_data, in, 1, upstream lane-select valid.
- sel_data, in, 4, upstream lane index, 1..TILING_SIZE.
- acc_data, in, TILING_SIZE*ACC_WIDTH, signed accumulators, lane 0 in LSBs.
- mem_ready, in, 1, memory accepts the write this cycle.
- wr_en, out, 1, write request.
- wr_addr, out, ADDR_WIDTH, write address.
- wr_data, out, DATA_WIDTH, write word.
- fifo_full, out, 1, FIFO holds FIFO_DEPTH entries.
- overflow_err, out, 1, sticky drop flag.
- done, out, 1, one-cycle pulse on the final write.

Function
REQ-003 Capture: valid_data=1 with sel_data in 1..TILING_SIZE SHALL select lane sel_data-1; sel_data=0 or sel_data>TILING_SIZE SHALL be ignored.
REQ-004 Conversion SHALL arithmetic-shift the lane right by SHIFT, then saturate to signed DATA_WIDTH (max 0x7FFF, min 0x8000 at 16 bits).
REQ-005 The converted word SHALL be registered in one pipeline stage and pushed into the FIFO on the following cycle (capture-to-push latency 1).
REQ-006 The FIFO SHALL be synchronous with FIFO_DEPTH entries, pushing at the tail and popping at the head in order.
REQ-007 A push SHALL be dropped when the FIFO is full and no pop occurs that cycle; the drop SHALL set overflow_err.
REQ-008 A simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-009 Write FSM states SHALL be IDLE, WRITE and FINISH.
REQ-010 IDLE SHALL go to WRITE when the FIFO is non-empty.
REQ-011 WRITE SHALL assert wr_en, with wr_data equal to the FIFO head.
REQ-012 A write is accepted when wr_en=1 and mem_ready=1; each accept SHALL pop the FIFO and increment wr_addr and the word count.
REQ-013 With mem_ready=0, wr_en, wr_data and wr_addr SHALL hold stable.
REQ-014 From WRITE, the accept of word out_len-1 SHALL go to FINISH; otherwise the FSM SHALL return to IDLE when the FIFO empties.
REQ-015 FINISH SHALL pulse done for 1 cycle, wrap wr_addr and the count to 0, and return to IDLE.
REQ-016 out_len=0 SHALL be treated as 2^ADDR_WIDTH.
REQ-017 clear SHALL override all other activity in its cycle.

Reset
REQ-018 rst_n=0 SHALL asynchronously force: FSM to IDLE, FIFO empty, pipeline stage invalid, and wr_en, wr_addr, wr_data, done, overflow_err and fifo_full to 0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered words; no write SHALL be issued in the cycle of reset release.

Configuration
REQ-020 With RELU_EN defined, the conversion SHALL clamp negative results to 0 after saturation.
REQ-021 Without RELU_EN, signed saturated results SHALL pass unchanged.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Lane 2 = 0x0000_1200, valid_data=1, sel_data=3, mem_ready=1 -> wr_data=0x0012 at wr_addr 0, 2 cycles after capture.
- Lane 0 = 0x7FFF_0000, sel_data=1 -> wr_data=0x7FFF; lane = 0xFFFF_FF00 -> 0xFFFF without RELU_EN, 0x0000 with RELU_EN.
- Upstream burst sel_data 0,1..8 with mem_ready=0 -> 4 words buffered, fifo_full=1, 4 drops, overflow_err=1.
- out_len=3, three accepts -> wr_addr 0,1,2, done pulse with the third accept, wr_addr returns to 0.
- mem_ready toggling 1,0,0,1 -> wr_data/wr_addr held during stall, no duplicate or skipped address.
- rst_n pulsed low with 3 words buffered -> wr_en=0, FIFO empty, overflow_err=0, and no write follows release.
